accumulator: RTL and testbench
==============================

// Module: accumulator
// PURPOSE
//   Free-running up/down counter with a snapshot output register.
//   The internal count steps by one on every clock. Direction is set by `mode`.
//   `show` copies the current count into the visible `acc` output, which holds between snapshots.
//   Standalone leaf block for counter/display demos; no handshake with neighbours.
// PARAMETERS
//   WIDTH   6   bit width of the internal count and of acc; arithmetic is modulo 2**WIDTH
// PORTS
//   clk    in   1      single clock; all state updates on rising edge
//   rst    in   1      reset, synchronous, active-low (0 = reset), sampled on rising clk edge
//   show   in   1      snapshot enable, level-sensitive, sampled each rising edge
//   mode   in   1      0 = count up (+1), 1 = count down (-1)
//   acc    out  WIDTH  registered snapshot of the internal count
// BEHAVIOUR
//   - State: count[WIDTH-1:0] (internal), acc[WIDTH-1:0] (output register). No FSM beyond this.
//   - Reset (rst==0 at a rising edge): count<=0, acc<=0. Reset has priority over show and mode.
//     Mid-operation reset clears both registers at that edge, whatever show and mode are.
//   - Normal edge (rst==1):
//       count <= mode ? count-1 : count+1 (wraps: 63+1->0, 0-1->63 for WIDTH=6)
//       if (show) acc <= count (value held BEFORE this edge's update); else acc holds
//   - Latency: acc reflects the pre-edge count one edge after show is sampled high.
//     While show stays high, acc tracks count delayed by one cycle.
//   - mode and show are sampled only at rising edges; a mode change takes effect on the next edge.
//     A show and a mode change at the same edge: the snapshot uses the old count, and count steps in the new direction.
//   - No overflow/underflow flags; wrap-around is silent and intended.
//   - acc is driven only from flops (no combinational path from inputs).
//   - After power-up without reset, state is undefined; benches must apply reset first.
// STRUCTURE
//   - No shared package needed.
//     Put WIDTH default and MODE_UP=1'b0 / MODE_DOWN=1'b1 localparams in the team's common constants package if one exists.
//   - One natural sub-module: acc_updown_counter (WIDTH param; clk, rst, mode -> count).
//     The top adds the show-gated acc snapshot register.
// TESTING
//   1. rst=0 for 2 edges, show=1, mode=0 -> acc==0 after each edge; internal count==0.
//   2. Release rst, show=0, mode=0, 5 edges -> acc stays 0 (count reaches 5 internally).
//   3. Continue from 2: show=1 for one edge, then 0 -> acc==5 and holds at 5 for following edges.
//   4. Reset, then mode=1, show=1 continuously -> acc sequence over successive edges 0, 63, 62, 61 (down wrap).
//   5. Reset, mode=0, show=0 for 64 edges, then show=1 one edge -> acc==0 (up wrap 63->0).
//      Repeat with 65 edges -> acc==1.
//   6. Mid-run reset: count at 10, show=1, mode=1, rst=0 for one edge -> acc==0 and count==0 at that edge.
//      Next edge with rst=1, mode=1, show=1 -> acc==0, count==63.

Source files
------------

// File: rtl/accumulator_pkg.sv
// Shared constants for the accumulator block.
//   ACC_WIDTH : default width of the internal count and the acc snapshot
//   MODE_UP / MODE_DOWN : encodings of the mode input
//   step_count() : one modulo-2**W step in the selected direction
package accumulator_pkg;

  localparam int   ACC_WIDTH = 6;
  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Overflow and underflow wrap silently; that is the intended behaviour.
  function automatic logic [ACC_WIDTH-1:0] step_count(
    input logic [ACC_WIDTH-1:0] cur,
    input logic                 mode
  );
    return (mode == MODE_DOWN) ? cur - ACC_WIDTH'(1) : cur + ACC_WIDTH'(1);
  endfunction

endpackage

// File: rtl/accumulator_if.sv
// Control and snapshot bus of the accumulator.
//   show : snapshot enable (master -> slave)
//   mode : count direction, 0 = up, 1 = down (master -> slave)
//   acc  : registered snapshot of the internal count (slave -> master)
interface accumulator_if #(
  parameter int WIDTH = 6
);
  logic             show;
  logic             mode;
  logic [WIDTH-1:0] acc;

  modport master (output show, output mode, input  acc);
  modport slave  (input  show, input  mode, output acc);
endinterface

// File: rtl/acc_updown_counter.sv
// Free-running modulo-2**WIDTH up/down counter.
//   clk   : clock, rising edge
//   rst   : synchronous reset, active low
//   mode  : 0 = +1 per edge, 1 = -1 per edge
//   count : current count
module acc_updown_counter
  import accumulator_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst)                   count <= '0;
    else if (mode == MODE_DOWN) count <= count - WIDTH'(1);
    else                        count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/accumulator.sv
// Up/down counter with a show-gated snapshot register.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low; overrides show and mode
//   bus.show : when high at an edge, acc captures the pre-edge count
//   bus.mode : counting direction, takes effect at the sampling edge
//   bus.acc  : snapshot output, driven straight from flops
module accumulator
  import accumulator_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  accumulator_if.slave   bus
);

  logic [WIDTH-1:0] count;

  acc_updown_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .mode  (bus.mode),
    .count (count)
  );

  // count here is the value before this edge's step, so with show held
  // high acc trails the counter by exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst)          bus.acc <= '0;
    else if (bus.show) bus.acc <= count;
  end

endmodule

// File: tb/tb_accumulator.sv
module tb_accumulator;
  localparam int W = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  accumulator_if #(.WIDTH(W)) bus ();

  accumulator #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change at edge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; bus.show = 1'b0; bus.mode = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.show = 1'b1; bus.mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.acc !== 6'd0) begin
        errors++; $display("FAIL reset_acc edge%0d got %0d want 0", i, bus.acc);
      end
      checks++;
      if (dut.u_cnt.count !== 6'd0) begin
        errors++; $display("FAIL reset_count edge%0d got %0d want 0", i, dut.u_cnt.count);
      end
    end
  endtask

  task automatic test_hidden_count();
    rst = 1'b1; bus.show = 1'b0; bus.mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.acc !== 6'd0) begin
        errors++; $display("FAIL hidden_acc edge%0d got %0d want 0", i, bus.acc);
      end
    end
    checks++;
    if (dut.u_cnt.count !== 6'd5) begin
      errors++; $display("FAIL hidden_count got %0d want 5", dut.u_cnt.count);
    end
  endtask

  task automatic test_snapshot_hold();
    bus.show = 1'b1;
    tick();
    checks++;
    if (bus.acc !== 6'd5) begin
      errors++; $display("FAIL snap_acc got %0d want 5", bus.acc);
    end
    bus.show = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.acc !== 6'd5) begin
        errors++; $display("FAIL snap_hold edge%0d got %0d want 5", i, bus.acc);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [W-1:0] exp [4];
    exp[0] = 6'd0; exp[1] = 6'd63; exp[2] = 6'd62; exp[3] = 6'd61;
    apply_reset();
    bus.mode = 1'b1; bus.show = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.acc !== exp[i]) begin
        errors++; $display("FAIL down_wrap edge%0d got %0d want %0d", i, bus.acc, exp[i]);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] exp [2];
    exp[0] = 6'd0; exp[1] = 6'd1;
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      bus.mode = 1'b0; bus.show = 1'b0;
      repeat (64 + r) tick();
      bus.show = 1'b1;
      tick();
      bus.show = 1'b0;
      checks++;
      if (bus.acc !== exp[r]) begin
        errors++; $display("FAIL up_wrap edges%0d got %0d want %0d", 64 + r, bus.acc, exp[r]);
      end
    end
  endtask

  task automatic test_mode_switch();
    // count at 3 counting up; show and mode flip at the same edge.
    apply_reset();
    bus.mode = 1'b0; bus.show = 1'b0;
    repeat (3) tick();
    bus.show = 1'b1; bus.mode = 1'b1;
    tick();
    checks++;
    if (bus.acc !== 6'd3) begin
      errors++; $display("FAIL switch_acc got %0d want 3", bus.acc);
    end
    checks++;
    if (dut.u_cnt.count !== 6'd2) begin
      errors++; $display("FAIL switch_count got %0d want 2", dut.u_cnt.count);
    end
    tick();
    checks++;
    if (bus.acc !== 6'd2) begin
      errors++; $display("FAIL switch_track got %0d want 2", bus.acc);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.mode = 1'b0; bus.show = 1'b0;
    repeat (10) tick();
    checks++;
    if (dut.u_cnt.count !== 6'd10) begin
      errors++; $display("FAIL mid_pre_count got %0d want 10", dut.u_cnt.count);
    end
    rst = 1'b0; bus.show = 1'b1; bus.mode = 1'b1;
    tick();
    checks++;
    if (bus.acc !== 6'd0) begin
      errors++; $display("FAIL mid_rst_acc got %0d want 0", bus.acc);
    end
    checks++;
    if (dut.u_cnt.count !== 6'd0) begin
      errors++; $display("FAIL mid_rst_count got %0d want 0", dut.u_cnt.count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.acc !== 6'd0) begin
      errors++; $display("FAIL mid_post_acc got %0d want 0", bus.acc);
    end
    checks++;
    if (dut.u_cnt.count !== 6'd63) begin
      errors++; $display("FAIL mid_post_count got %0d want 63", dut.u_cnt.count);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; bus.show = 1'b0; bus.mode = 1'b0;
    test_reset();
    test_hidden_count();
    test_snapshot_hold();
    test_down_wrap();
    test_up_wrap();
    test_mode_switch();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
